// File: rtl/ball_bounce_ctrl.sv
// Ball bounce controller: paces moves off frame ticks, resolves wall/paddle collisions and tracks lives.
// Optional BALL_SPEEDUP_EN: every 4th paddle hit shortens the move interval by one frame (minimum 1).
module ball_bounce_ctrl #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 32,
    parameter int STEP      = 3,
    parameter int PADDLE_Y  = 440,
    parameter int PADDLE_W  = 64,
    parameter int FRAME_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frameTick,
    input  logic       serve,
    input  logic [9:0] xPos,
    input  logic [9:0] yPos,
    input  logic [9:0] paddleX,
    output logic [1:0] direction,
    output logic       ballPosUpdate,
    output logic       paddleHit,
    output logic       missed,
    output logic [1:0] lives,
    output logic [7:0] hitCount,
    output logic       gameOver
);

    typedef enum logic [2:0] {IDLE, RUN, CHECK, UPDATE, MISS, OVER} state_t;

    localparam logic [10:0] STEP_U  = 11'(STEP);
    localparam logic [10:0] BALL_U  = 11'(BALL_SIZE);
    localparam logic [10:0] SCR_W_U = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H_U = 11'(SCREEN_H);
    localparam logic [10:0] PAD_Y_U = 11'(PADDLE_Y);
    localparam logic [10:0] PAD_W_U = 11'(PADDLE_W);
    localparam logic [7:0]  DIV_INIT = 8'(FRAME_DIV);

    state_t      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [7:0]  div_load_q, div_load_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic        upd_q, upd_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;

    logic [10:0] x_u, y_u, px_u;
    logic        hit_now, miss_now;
    logic [1:0]  dir_chk;
    logic [7:0]  hit_inc;

    // Widen to 11 bits so position + size + step sums never wrap.
    assign x_u     = {1'b0, xPos};
    assign y_u     = {1'b0, yPos};
    assign px_u    = {1'b0, paddleX};
    assign hit_inc = hit_cnt_q + 8'd1;

    assign hit_now = !dir_q[1]
                     && (y_u + BALL_U <= PAD_Y_U)
                     && (PAD_Y_U < y_u + BALL_U + STEP_U)
                     && (x_u + BALL_U > px_u)
                     && (x_u < px_u + PAD_W_U);
    assign miss_now = !dir_q[1] && !hit_now && (y_u + BALL_U + STEP_U > SCR_H_U);

    always_comb begin
        dir_chk = dir_q;
        if (dir_q[0] && (x_u < STEP_U))
            dir_chk[0] = 1'b0;
        if (!dir_q[0] && (x_u + BALL_U + STEP_U > SCR_W_U))
            dir_chk[0] = 1'b1;
        if (dir_q[1] && (y_u < STEP_U))
            dir_chk[1] = 1'b0;
        if (hit_now)
            dir_chk[1] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        div_cnt_d  = div_cnt_q;
        div_load_d = div_load_q;
        lives_d    = lives_q;
        hit_cnt_d  = hit_cnt_q;
        upd_d      = 1'b0;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        case (state_q)
            IDLE, MISS: begin
                if (serve) begin
                    state_d   = RUN;
                    dir_d     = 2'b10;
                    div_cnt_d = 8'd0;
                end
            end
            RUN: begin
                if (frameTick) begin
                    if (div_cnt_q == div_load_q - 8'd1) begin
                        div_cnt_d = 8'd0;
                        state_d   = CHECK;
                    end else begin
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                end
            end
            CHECK: begin
                dir_d = dir_chk;
                if (hit_now) begin
                    hit_d = 1'b1;
                    if (hit_cnt_q != 8'hFF) begin
                        hit_cnt_d = hit_inc;
`ifdef BALL_SPEEDUP_EN
                        if ((hit_inc[1:0] == 2'b00) && (div_load_q > 8'd1))
                            div_load_d = div_load_q - 8'd1;
`else
                        div_load_d = DIV_INIT;
`endif
                    end
                end
                if (miss_now) begin
                    miss_d  = 1'b1;
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? OVER : MISS;
                end else begin
                    upd_d   = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE:  state_d = RUN;
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= 2'b10;
            div_cnt_q  <= 8'd0;
            div_load_q <= DIV_INIT;
            lives_q    <= 2'd3;
            hit_cnt_q  <= 8'd0;
            upd_q      <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            div_cnt_q  <= div_cnt_d;
            div_load_q <= div_load_d;
            lives_q    <= lives_d;
            hit_cnt_q  <= hit_cnt_d;
            upd_q      <= upd_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign direction     = dir_q;
    assign ballPosUpdate = upd_q;
    assign paddleHit     = hit_q;
    assign missed        = miss_q;
    assign lives         = lives_q;
    assign hitCount      = hit_cnt_q;
    assign gameOver      = (state_q == OVER);

endmodule

// File: tb/tb_ball_bounce_ctrl.sv
// Directed bench for ball_bounce_ctrl: moves, bounces, paddle hits, misses, reset and interval pacing.
module tb_ball_bounce_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frameTick, serve;
    logic [9:0] xPos, yPos, paddleX;
    logic [1:0] direction;
    logic       ballPosUpdate, paddleHit, missed;
    logic [1:0] lives;
    logic [7:0] hitCount;
    logic       gameOver;

    int passed = 0;
    int total  = 0;

    logic       t_u0, t_u1, t_u2, t_h, t_m, r_early;
    logic [1:0] t_dir;
    int         exp_div, exp_hits;

    ball_bounce_ctrl dut (
        .clk(clk), .rst(rst), .frameTick(frameTick), .serve(serve),
        .xPos(xPos), .yPos(yPos), .paddleX(paddleX),
        .direction(direction), .ballPosUpdate(ballPosUpdate),
        .paddleHit(paddleHit), .missed(missed), .lives(lives),
        .hitCount(hitCount), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // One frame tick; samples the cycle after the tick, the move cycle, and the cycle after it.
    task automatic tick_once();
        @(negedge clk); frameTick = 1'b1;
        @(negedge clk); frameTick = 1'b0;
        t_u0 = ballPosUpdate | paddleHit | missed;
        @(negedge clk);
        t_u1 = ballPosUpdate; t_h = paddleHit; t_m = missed; t_dir = direction;
        @(negedge clk);
        t_u2 = ballPosUpdate | paddleHit | missed;
    endtask

    task automatic interval(input logic [9:0] x, input logic [9:0] y, input logic [9:0] px, input int n);
        xPos = x; yPos = y; paddleX = px; r_early = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick_once();
            r_early = r_early | t_u0 | t_u2;
            if (i < n - 1) r_early = r_early | t_u1 | t_h | t_m;
        end
    endtask

    task automatic do_serve();
        @(negedge clk); serve = 1'b1;
        @(negedge clk); serve = 1'b0;
    endtask

    task automatic note_hit();
        exp_hits++;
`ifdef BALL_SPEEDUP_EN
        if ((exp_hits % 4 == 0) && (exp_div > 1)) exp_div--;
`endif
    endtask

    initial begin
        rst = 1'b0; frameTick = 1'b0; serve = 1'b0;
        xPos = '0; yPos = '0; paddleX = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_dir", direction, 2'b10);
        chk("rst_lives", lives, 3);
        chk("rst_hits", hitCount, 0);
        chk("rst_over", gameOver, 0);
        chk("rst_pulses", {ballPosUpdate, paddleHit, missed}, 0);
        @(negedge clk); @(negedge clk); rst = 1'b0;

        tick_once();
        chk("idle_tick_dropped", t_u1, 0);
        do_serve();
        chk("serve_dir", direction, 2'b10);

        interval(10'd300, 10'd300, 10'd0, 4);
        chk("move_early", r_early, 0);
        chk("move_upd", t_u1, 1);
        chk("move_dir", t_dir, 2'b10);

        interval(10'd300, 10'd0, 10'd0, 4);
        chk("top_dir", t_dir, 2'b00);

        interval(10'd606, 10'd200, 10'd0, 4);
        chk("right_dir", t_dir, 2'b01);
        chk("right_upd", t_u1, 1);

        interval(10'd300, 10'd407, 10'd280, 4);
        chk("hit_nv_dir", t_dir, 2'b11);
        chk("hit_nv_pulse", t_h, 1);

        interval(10'd1, 10'd2, 10'd0, 4);
        chk("corner_dir", t_dir, 2'b00);
        chk("corner_upd", t_u1, 1);

        interval(10'd300, 10'd407, 10'd280, 4);
        chk("hit_dir", t_dir, 2'b10);
        chk("hit_pulse", t_h, 1);
        chk("hit_upd", t_u1, 1);
        chk("hit_count", hitCount, 2);

        interval(10'd300, 10'd0, 10'd0, 4);
        interval(10'd300, 10'd407, 10'd400, 4);
        chk("nohit_dir", t_dir, 2'b00);
        chk("nohit_pulse", t_h, 0);
        chk("nohit_count", hitCount, 2);

        interval(10'd0, 10'd446, 10'd500, 4);
        chk("miss1_pulse", t_m, 1);
        chk("miss1_noupd", t_u1, 0);
        chk("miss1_lives", lives, 2);
        tick_once();
        chk("miss_tick_dropped", t_u1, 0);
        do_serve();
        chk("miss_serve_dir", direction, 2'b10);
        interval(10'd300, 10'd0, 10'd0, 4);
        interval(10'd0, 10'd446, 10'd500, 4);
        chk("miss2_pulse", t_m, 1);
        chk("miss2_lives", lives, 1);
        chk("miss2_over", gameOver, 0);
        do_serve();
        interval(10'd300, 10'd0, 10'd0, 4);
        interval(10'd0, 10'd446, 10'd500, 4);
        chk("miss3_pulse", t_m, 1);
        chk("miss3_lives", lives, 0);
        chk("miss3_over", gameOver, 1);
        do_serve();
        chk("over_serve_dir", direction, 2'b00);
        tick_once();
        chk("over_tick_dropped", t_u1, 0);
        chk("over_stays", gameOver, 1);

        @(negedge clk); rst = 1'b1;
        #1;
        chk("rst2_lives", lives, 3);
        chk("rst2_over", gameOver, 0);
        chk("rst2_dir", direction, 2'b10);
        @(negedge clk); rst = 1'b0;

        do_serve();
        xPos = 10'd300; yPos = 10'd300; paddleX = 10'd0;
        for (int i = 0; i < 3; i++) tick_once();
        @(negedge clk); frameTick = 1'b1;
        @(negedge clk); frameTick = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_check_noupd", ballPosUpdate, 0);
        rst = 1'b0;

        exp_div = 4; exp_hits = 0;
        do_serve();
        for (int h = 0; h < 4; h++) begin
            interval(10'd300, 10'd0, 10'd0, exp_div);
            interval(10'd300, 10'd407, 10'd280, exp_div);
            chk("pace_hit", t_h, 1);
            note_hit();
        end
        chk("pace_hits4", hitCount, 4);
`ifdef BALL_SPEEDUP_EN
        interval(10'd300, 10'd300, 10'd0, 3);
`else
        interval(10'd300, 10'd300, 10'd0, 4);
`endif
        chk("pace4_early", r_early, 0);
        chk("pace4_upd", t_u1, 1);
`ifdef BALL_SPEEDUP_EN
        for (int h = 0; h < 16; h++) begin
            interval(10'd300, 10'd0, 10'd0, exp_div);
            interval(10'd300, 10'd407, 10'd280, exp_div);
            chk("speed_hit_upd", t_u1, 1);
            note_hit();
        end
        chk("speed_hits20", hitCount, 20);
        interval(10'd300, 10'd300, 10'd0, 1);
        chk("speed_min_upd", t_u1, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
